icache_refill_ctrl: RTL

Miss handler sitting directly upstream of the instruction cache's refill port. It watches the cache's registered miss flag and issues one line-aligned burst read to the memory bus. It forwards the returned words in order on `refill_valid`/`refill_data`, waits for the cache's `refill_complete`, then re-arms. It also handles flush mid-burst, draining outstanding beats, and detects malformed bursts.

---
 rtl/icache_refill_ctrl_if.sv | 35 +++
 rtl/icache_refill_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/icache_refill_ctrl_if.sv
// Bundle between the refill controller, the instruction cache and the memory read bus.
// master is the controller's view; slave is the cache/memory side.
interface icache_refill_ctrl_if #(
    parameter int unsigned DATA_LENGTH = 32
);
    logic                   flush;
    logic                   miss;
    logic [31:0]            miss_addr;
    logic                   refill_complete;
    logic                   mem_req_valid;
    logic                   mem_req_ready;
    logic [31:0]            mem_req_addr;
    logic [7:0]             mem_req_len;
    logic                   mem_rvalid;
    logic [DATA_LENGTH-1:0] mem_rdata;
    logic                   mem_rlast;
    logic                   refill_valid;
    logic [DATA_LENGTH-1:0] refill_data;
    logic                   busy;
    logic                   refill_err;

    modport master (
        input  flush, miss, miss_addr, refill_complete,
        input  mem_req_ready, mem_rvalid, mem_rdata, mem_rlast,
        output mem_req_valid, mem_req_addr, mem_req_len,
        output refill_valid, refill_data, busy, refill_err
    );

    modport slave (
        output flush, miss, miss_addr, refill_complete,
        output mem_req_ready, mem_rvalid, mem_rdata, mem_rlast,
        input  mem_req_valid, mem_req_addr, mem_req_len,
        input  refill_valid, refill_data, busy, refill_err
    );
endinterface

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss handler: one line-aligned burst read per miss, words forwarded
// in order to the cache, with flush draining and malformed-burst detection.
module icache_refill_ctrl #(
    parameter int unsigned DATA_LENGTH = 32,
    parameter int unsigned LINE_SIZE   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    icache_refill_ctrl_if.master bus
);
    localparam int unsigned WORDS = LINE_SIZE / (DATA_LENGTH / 8);
    localparam int unsigned OFF   = $clog2(LINE_SIZE);
    localparam int unsigned CW    = 5;
    localparam logic [CW-1:0] LAST_BEAT = CW'(WORDS - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] REQ      = 3'd1;
    localparam logic [2:0] FILL     = 3'd2;
    localparam logic [2:0] WAIT_ACK = 3'd3;
    localparam logic [2:0] HOLDOFF  = 3'd4;
    localparam logic [2:0] DRAIN    = 3'd5;

    logic [2:0]             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [31:0]            addr_q, addr_d;
    logic                   pend_q, pend_d;
    logic                   req_valid_q;
    logic                   rv_q, rv_d;
    logic [DATA_LENGTH-1:0] data_q, data_d;
    logic                   err_q, err_d;
    logic                   busy_q;

    // Offset bits are dropped by line alignment.
    logic [OFF-1:0] unused_addr_bits;
    assign unused_addr_bits = bus.miss_addr[OFF-1:0];

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        pend_d  = pend_q;
        rv_d    = 1'b0;
        data_d  = data_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.miss && !bus.flush) begin
                    addr_d  = {bus.miss_addr[31:OFF], OFF'(0)};
                    pend_d  = 1'b0;
                    state_d = REQ;
                end
            end
            REQ: begin
                // The request is never withdrawn; a flush only redirects the burst to DRAIN.
                if (bus.flush) pend_d = 1'b1;
                if (bus.mem_req_ready) begin
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                    state_d = (pend_q || bus.flush) ? DRAIN : FILL;
                end
            end
            FILL: begin
                if (bus.flush) begin
                    state_d = DRAIN;
                    if (bus.mem_rvalid) begin
                        cnt_d = cnt_q + CW'(1);
                        if (bus.mem_rlast) state_d = IDLE;
                    end
                end else if (bus.mem_rvalid) begin
                    rv_d   = 1'b1;
                    data_d = bus.mem_rdata;
                    cnt_d  = cnt_q + CW'(1);
                    if (bus.mem_rlast && cnt_q == LAST_BEAT) begin
                        state_d = WAIT_ACK;
                    end else if (bus.mem_rlast) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else if (cnt_q == LAST_BEAT) begin
                        err_d   = 1'b1;
                        state_d = DRAIN;
                    end
                end
            end
            WAIT_ACK: begin
                if (bus.flush)                state_d = IDLE;
                else if (bus.refill_complete) state_d = HOLDOFF;
            end
            HOLDOFF: state_d = IDLE;
            DRAIN: begin
                if (bus.mem_rvalid && bus.mem_rlast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            pend_q      <= 1'b0;
            req_valid_q <= 1'b0;
            rv_q        <= 1'b0;
            data_q      <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            pend_q      <= pend_d;
            req_valid_q <= (state_d == REQ);
            rv_q        <= rv_d;
            data_q      <= data_d;
            err_q       <= err_d;
            busy_q      <= (state_d != IDLE);
        end
    end

    assign bus.mem_req_valid = req_valid_q;
    assign bus.mem_req_addr  = addr_q;
    assign bus.mem_req_len   = 8'(WORDS - 1);
    assign bus.refill_valid  = rv_q;
    assign bus.refill_data   = data_q;
    assign bus.busy          = busy_q;
    assign bus.refill_err    = err_q;
endmodule
